// File: rtl/sim_data_checker_pkg.sv
// Shared types, widths and helpers for the sequential data checker.
package sim_data_checker_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    CHECK      = 2'd2,
    DONE       = 2'd3
  } state_e;

  // Increment that sticks at max; narrower counters pass a zero-extended max.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v,
                                                input logic [DATA_W-1:0] max);
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/sim_data_checker_if.sv
// Stream-in / status-out bundle between the FIFO read side and the checker.
interface sim_data_checker_if
  import sim_data_checker_pkg::*;
#(
  parameter int ERR_CNT_W = 16
);
  logic                 Enable;
  logic                 Clear;
  logic [DATA_W-1:0]    DataIn;
  logic                 DataInValid;
  logic                 Locked;
  logic                 ErrFlag;
  logic [ERR_CNT_W-1:0] ErrCnt;
  logic [DATA_W-1:0]    WordCnt;
  logic [DATA_W-1:0]    FirstErrExp;
  logic [DATA_W-1:0]    FirstErrGot;
  logic                 Done;

  modport master (
    output Enable, Clear, DataIn, DataInValid,
    input  Locked, ErrFlag, ErrCnt, WordCnt, FirstErrExp, FirstErrGot, Done
  );

  modport slave (
    input  Enable, Clear, DataIn, DataInValid,
    output Locked, ErrFlag, ErrCnt, WordCnt, FirstErrExp, FirstErrGot, Done
  );
endinterface

// File: rtl/sim_data_checker_seq_compare.sv
// Holds the expected next word and compares the incoming word against it.
// The first word after (re)sync is compared against START_VALUE instead,
// and only when strict start checking is on.
module sim_data_checker_seq_compare
  import sim_data_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] START_VALUE  = 32'd1,
  parameter bit                STRICT_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,     // drop the expected value (Clear / Enable low)
  input  logic              load,      // a word is being accepted this cycle
  input  logic              first,     // this word seeds the sequence
  input  logic [DATA_W-1:0] data_in,
  output logic              mismatch,
  output logic [DATA_W-1:0] ref_val,   // value the word was compared against
  output logic [DATA_W-1:0] nxt_exp
);

  logic [DATA_W-1:0] expected;

  // Plain 32-bit add: FFFF_FFFF + 1 wraps to 0, which is the generator's wrap.
  assign nxt_exp  = data_in + 1'b1;
  assign ref_val  = first ? START_VALUE : expected;
  assign mismatch = first ? (STRICT_START && (data_in != START_VALUE))
                          : (data_in != expected);

  // Always resync to the received word so a single bad word costs at most two errors.
  always_ff @(posedge clk) begin
    if (rst || flush) expected <= '0;
    else if (load)    expected <= nxt_exp;
  end

endmodule

// File: rtl/sim_data_checker.sv
// Receive-side checker for the incrementing-count test stream: lock, error
// statistics, first-error snapshot and completion flag.
module sim_data_checker
  import sim_data_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] START_VALUE  = 32'd1,
  parameter bit                STRICT_START = 1'b1,
  parameter logic [DATA_W-1:0] TARGET_WORDS = 32'd1048576,
  parameter int                ERR_CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  sim_data_checker_if.slave bus
);

  localparam logic [DATA_W-1:0] ERR_MAX  = DATA_W'({ERR_CNT_W{1'b1}});
  localparam logic [DATA_W-1:0] WORD_MAX = '1;

  state_e               state;
  logic                 locked, err_flag, done;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [DATA_W-1:0]    word_cnt, fe_exp, fe_got;

  logic                 mismatch;
  logic [DATA_W-1:0]    ref_val, nxt_exp;
  logic [DATA_W-1:0]    wc_nxt;
  logic [ERR_CNT_W-1:0] ec_nxt;

  assign wc_nxt = sat_inc(word_cnt, WORD_MAX);
  assign ec_nxt = ERR_CNT_W'(sat_inc(DATA_W'(err_cnt), ERR_MAX));

  sim_data_checker_seq_compare #(
    .START_VALUE  (START_VALUE),
    .STRICT_START (STRICT_START)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.Clear || !bus.Enable),
    .load     ((state != IDLE) && bus.DataInValid),
    .first    (state == WAIT_FIRST),
    .data_in  (bus.DataIn),
    .mismatch (mismatch),
    .ref_val  (ref_val),
    .nxt_exp  (nxt_exp)
  );

  // Sync FSM plus statistics; Clear lands directly in WAIT_FIRST when enabled
  // so the word right after it is taken as the new seed.
  always_ff @(posedge clk) begin
    if (rst || bus.Clear) begin
      state    <= (!rst && bus.Enable) ? WAIT_FIRST : IDLE;
      locked   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
      word_cnt <= '0;
      fe_exp   <= '0;
      fe_got   <= '0;
      done     <= 1'b0;
    end else if (!bus.Enable) begin
      state  <= IDLE;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= WAIT_FIRST;
        default: begin
          if (bus.DataInValid) begin
            word_cnt <= wc_nxt;
            locked   <= 1'b1;
            if (mismatch) begin
              err_cnt  <= ec_nxt;
              err_flag <= 1'b1;
              if (!err_flag) begin
                fe_exp <= ref_val;
                fe_got <= bus.DataIn;
              end
            end
            if (done || (wc_nxt == TARGET_WORDS)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
      endcase
    end
  end

  assign bus.Locked      = locked;
  assign bus.ErrFlag     = err_flag;
  assign bus.ErrCnt      = err_cnt;
  assign bus.WordCnt     = word_cnt;
  assign bus.FirstErrExp = fe_exp;
  assign bus.FirstErrGot = fe_got;
  assign bus.Done        = done;

  // nxt_exp is consumed inside the comparator; kept on the port for debug taps.
  logic unused_nxt;
  assign unused_nxt = ^nxt_exp;

endmodule

// File: tb/tb_sim_data_checker.sv
// Randomised + directed bench for sim_data_checker. Two instances see the same
// stream: A (strict start, target 100, 16-bit errors) and B (free seed,
// target 1, 3-bit errors so saturation is reachable).
module tb_sim_data_checker;
  import sim_data_checker_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clr = 1'b0, vld = 1'b0;
  logic [31:0] dat = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_data_checker_if #(.ERR_CNT_W(16)) ifa ();
  sim_data_checker_if #(.ERR_CNT_W(3))  ifb ();

  assign ifa.Enable = en;  assign ifa.Clear = clr;
  assign ifa.DataIn = dat; assign ifa.DataInValid = vld;
  assign ifb.Enable = en;  assign ifb.Clear = clr;
  assign ifb.DataIn = dat; assign ifb.DataInValid = vld;

  sim_data_checker #(.START_VALUE(32'd1), .STRICT_START(1'b1),
                     .TARGET_WORDS(32'd100), .ERR_CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sim_data_checker #(.START_VALUE(32'd1), .STRICT_START(1'b0),
                     .TARGET_WORDS(32'd1), .ERR_CNT_W(3))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Behavioural model: "armed" = enabled and past the one idle cycle,
  // "seeded" = a first word has been taken since arming.
  typedef struct {
    bit          armed, seeded, flag, done;
    logic [31:0] exp, ec, wc, fexp, fgot;
  } m_t;

  m_t ma, mb;

  function automatic m_t step(m_t m, bit strict, logic [31:0] start,
                              logic [31:0] target, logic [31:0] emax,
                              bit r, bit c, bit e, bit v, logic [31:0] d);
    m_t n;
    n = m;
    if (r || c) begin
      n = '{default: 0};
      n.armed = !r && e;
    end else if (!e) begin
      n.armed  = 0;
      n.seeded = 0;
    end else if (!m.armed) begin
      n.armed = 1;
    end else if (v) begin
      bit bad;
      bad = m.seeded ? (d != m.exp) : (strict && d != start);
      if (bad) begin
        if (!m.flag) begin
          n.fexp = m.seeded ? m.exp : start;
          n.fgot = d;
        end
        n.flag = 1;
        if (m.ec < emax) n.ec = m.ec + 1;
      end
      if (m.wc != 32'hFFFF_FFFF) n.wc = m.wc + 1;
      if (n.wc == target) n.done = 1;
      n.exp    = d + 32'd1;
      n.seeded = 1;
    end
    return n;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model advance on every edge, then compare both instances just after it.
  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
  end
  always @(posedge clk) begin
    ma = step(ma, 1'b1, 32'd1, 32'd100, 32'h0000_FFFF, rst, clr, en, vld, dat);
    mb = step(mb, 1'b0, 32'd1, 32'd1,   32'h0000_0007, rst, clr, en, vld, dat);
    #1;
    cmp("A.Locked",  32'(ifa.Locked),  32'(ma.seeded));
    cmp("A.ErrFlag", 32'(ifa.ErrFlag), 32'(ma.flag));
    cmp("A.ErrCnt",  32'(ifa.ErrCnt),  ma.ec);
    cmp("A.WordCnt", ifa.WordCnt,      ma.wc);
    cmp("A.FErrExp", ifa.FirstErrExp,  ma.fexp);
    cmp("A.FErrGot", ifa.FirstErrGot,  ma.fgot);
    cmp("A.Done",    32'(ifa.Done),    32'(ma.done));
    cmp("B.Locked",  32'(ifb.Locked),  32'(mb.seeded));
    cmp("B.ErrFlag", 32'(ifb.ErrFlag), 32'(mb.flag));
    cmp("B.ErrCnt",  32'(ifb.ErrCnt),  mb.ec);
    cmp("B.WordCnt", ifb.WordCnt,      mb.wc);
    cmp("B.FErrExp", ifb.FirstErrExp,  mb.fexp);
    cmp("B.FErrGot", ifb.FirstErrGot,  mb.fgot);
    cmp("B.Done",    32'(ifb.Done),    32'(mb.done));
  end

  task automatic drive(input bit e, input bit c, input bit v, input logic [31:0] d);
    @(negedge clk);
    en = e; clr = c; vld = v; dat = d;
  endtask
  task automatic feed(input logic [31:0] d);  drive(1'b1, 1'b0, 1'b1, d); endtask
  task automatic gap();                       drive(en, 1'b0, 1'b0, dat); endtask
  task automatic clear_pulse();               drive(1'b1, 1'b1, 1'b0, '0); endtask
  task automatic feed_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) feed(32'(i));
  endtask

  logic [31:0] g;
  int r;

  initial begin
    // Reset state
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    cmp("rst.WordCnt", ifa.WordCnt, 32'd0);
    cmp("rst.Locked",  32'(ifa.Locked), 32'd0);
    cmp("rst.Done",    32'(ifb.Done), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Clean stream 1..100
    drive(1'b1, 1'b0, 1'b0, '0);
    feed(32'd1); gap();
    cmp("clean.Locked1", 32'(ifa.Locked), 32'd1);
    feed_range(2, 99); gap();
    cmp("clean.Done99", 32'(ifa.Done), 32'd0);
    feed(32'd100); gap();
    cmp("clean.WordCnt", ifa.WordCnt, 32'd100);
    cmp("clean.Done",    32'(ifa.Done), 32'd1);
    cmp("clean.ErrCnt",  32'(ifa.ErrCnt), 32'd0);
    cmp("clean.ErrFlag", 32'(ifa.ErrFlag), 32'd0);
    cmp("clean.B.Done",  32'(ifb.Done), 32'd1);

    // Gapped stream 1..50
    clear_pulse();
    for (int i = 1; i <= 50; i++) begin
      while ($urandom_range(0, 2) == 0) gap();
      feed(32'(i));
    end
    gap();
    cmp("gap.ErrCnt",  32'(ifa.ErrCnt), 32'd0);
    cmp("gap.WordCnt", ifa.WordCnt, 32'd50);

    // Dropped word 11
    clear_pulse();
    feed_range(1, 10); feed_range(12, 20); gap();
    cmp("drop.ErrCnt",  32'(ifa.ErrCnt), 32'd1);
    cmp("drop.FErrExp", ifa.FirstErrExp, 32'd11);
    cmp("drop.FErrGot", ifa.FirstErrGot, 32'd12);
    cmp("drop.WordCnt", ifa.WordCnt, 32'd19);

    // Corrupt word 6
    clear_pulse();
    feed_range(1, 5); feed(32'hDEAD); feed_range(7, 9); gap();
    cmp("corr.ErrCnt",  32'(ifa.ErrCnt), 32'd2);
    cmp("corr.FErrExp", ifa.FirstErrExp, 32'd6);
    cmp("corr.FErrGot", ifa.FirstErrGot, 32'h0000_DEAD);

    // Enable low then restart from 1
    clear_pulse();
    feed_range(1, 10);
    drive(1'b0, 1'b0, 1'b0, '0); drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    feed_range(1, 5); gap();
    cmp("restart.ErrCnt",  32'(ifa.ErrCnt), 32'd0);
    cmp("restart.WordCnt", ifa.WordCnt, 32'd15);

    // Strict start violation
    clear_pulse();
    feed(32'd5); feed(32'd6); feed(32'd7); gap();
    cmp("strict.ErrCnt",  32'(ifa.ErrCnt), 32'd1);
    cmp("strict.FErrExp", ifa.FirstErrExp, 32'd1);
    cmp("strict.FErrGot", ifa.FirstErrGot, 32'd5);
    cmp("strict.B.ErrCnt", 32'(ifb.ErrCnt), 32'd0);

    // Clear concurrent with a valid word, then reseed
    clear_pulse();
    feed_range(1, 3);
    drive(1'b1, 1'b1, 1'b1, 32'd99); gap();
    cmp("clrv.WordCnt", ifa.WordCnt, 32'd0);
    cmp("clrv.Locked",  32'(ifa.Locked), 32'd0);
    feed(32'd500); feed(32'd501); gap();
    cmp("clrv.B.ErrCnt",  32'(ifb.ErrCnt), 32'd0);
    cmp("clrv.B.WordCnt", ifb.WordCnt, 32'd2);
    cmp("clrv.B.Locked",  32'(ifb.Locked), 32'd1);

    // Wrap through zero (B seeds freely)
    clear_pulse();
    feed(32'hFFFF_FFFE); feed(32'hFFFF_FFFF); feed(32'h0); feed(32'h1); gap();
    cmp("wrap.B.ErrCnt",  32'(ifb.ErrCnt), 32'd0);
    cmp("wrap.B.WordCnt", ifb.WordCnt, 32'd4);
    cmp("wrap.A.ErrCnt",  32'(ifa.ErrCnt), 32'd1);

    // 3-bit error counter saturation on B
    clear_pulse();
    for (int i = 0; i <= 10; i++) feed(32'(i * 5));
    gap();
    cmp("sat.B.ErrCnt",  32'(ifb.ErrCnt), 32'd7);
    cmp("sat.B.FErrExp", ifb.FirstErrExp, 32'd1);
    cmp("sat.B.FErrGot", ifb.FirstErrGot, 32'd5);

    // Mid-stream reset, then resync
    feed(32'd77);
    @(negedge clk) begin rst = 1'b1; vld = 1'b1; dat = 32'd78; end
    @(negedge clk) rst = 1'b0;
    cmp("rstmid.WordCnt", ifa.WordCnt, 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0);

    // Randomised stream with gaps, drops, corruption, clears, enable toggles
    g = 32'd1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        @(negedge clk) begin rst = 1'b1; vld = 1'b0; clr = 1'b0; end
        @(negedge clk) rst = 1'b0;
        g = 32'd1;
      end else if (r < 4) begin
        drive(1'b1, 1'b1, $urandom_range(0, 1) == 1, g);
        g = 32'd1;
      end else if (r < 8) begin
        drive(1'b0, 1'b0, $urandom_range(0, 1) == 1, g);
        g = 32'd1;
      end else if (r < 10) begin
        g = 32'hFFFF_FFF0 + 32'($urandom_range(0, 12));
        feed(g); g = g + 32'd1;
      end else if (r < 60) begin
        gap();
      end else if (r < 66) begin
        feed($urandom);
        g = g + 32'd1;
      end else if (r < 72) begin
        g = g + 32'd1;
        feed(g); g = g + 32'd1;
      end else begin
        feed(g); g = g + 32'd1;
      end
    end
    gap(); gap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_data_checker.md
Name: sim_data_checker

Overview:
- Receive-side counterpart of the simulation data generator. Sits at the read port of the DDR FIFO path.
- Checks that the returned 32-bit stream is the generator's incrementing count: consecutive valid words differ by +1 modulo 2^32.
- Reports lock, mismatch statistics, the first-error snapshot and test completion to the testbench or ILA.
- Valid gaps (FIFO read stalls) are legal and never counted as errors.

Parameters:
- START_VALUE, 32'd1, first word the generator emits after enable rises; used only when STRICT_START=1.
- STRICT_START, 1, 1: first word must equal START_VALUE; 0: first word seeds the expected value unchecked.
- TARGET_WORDS, 32'd1048576, number of checked words after which Done asserts.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- Enable  input  1  checking enabled; low returns to IDLE and holds statistics
- Clear  input  1  single-cycle pulse, zeroes statistics and restarts synchronisation
- DataIn  input  32  received data word
- DataInValid  input  1  DataIn qualifier
- Locked  output  1  checker is in CHECK or DONE
- ErrFlag  output  1  sticky, set on the first mismatch
- ErrCnt  output  ERR_CNT_W  mismatch count, saturates at all-ones
- WordCnt  output  32  valid words checked since the last Clear/rst, saturates at 2^32-1
- FirstErrExp  output  32  expected value at the first mismatch
- FirstErrGot  output  32  received value at the first mismatch
- Done  output  1  WordCnt reached TARGET_WORDS, sticky until Clear/rst

Behaviour:
- Reset: all outputs 0; state IDLE; internal Expected = 0.
- Priority order: rst > Clear > Enable low > normal operation.
- Clear: same effect as rst, but only when rst is low.
- All outputs are registered. The effect of the word accepted at edge N is visible after edge N.
- States:
  - IDLE: Enable=1 -> WAIT_FIRST.
  - WAIT_FIRST: on DataInValid:
    - Expected <= DataIn+1; WordCnt += 1; go to CHECK.
    - If STRICT_START=1 and DataIn != START_VALUE: record a mismatch against START_VALUE (ErrCnt += 1, ErrFlag, first-error snapshot), then still go to CHECK.
  - CHECK: on DataInValid:
    - Compare DataIn against Expected. Mismatch: ErrCnt += 1 (saturating), ErrFlag <= 1.
    - If ErrFlag was 0 before this word: FirstErrExp <= Expected, FirstErrGot <= DataIn.
    - Always: Expected <= DataIn+1 (resync, so one corrupted word costs at most 2 errors and a dropped word costs 1); WordCnt += 1.
  - DONE: entered when WordCnt becomes TARGET_WORDS; Done <= 1. Keeps checking and counting exactly as in CHECK.
  - Any state with Enable=0 -> IDLE. Statistics, Done, ErrFlag and snapshots are held; Expected is not. Enable high again -> WAIT_FIRST, so the generator restart from 1 is not an error.
- Wrap: Expected after 32'hFFFF_FFFF is 32'h0000_0000, which is not a mismatch. The +1 is 32-bit modular.
- DataInValid=0: no state, counter or Expected change.
- Clear and DataInValid in the same cycle: the word is discarded and the checker starts in WAIT_FIRST (or IDLE if Enable=0).
- TARGET_WORDS=0 is not supported (tie-off); TARGET_WORDS=1 -> Done on the first word.
- rst mid-stream: everything is cleared next cycle and resync occurs on the next valid word.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT_FIRST, CHECK, DONE)
  - DATA_W=32 constant
  - saturating-increment function, reused by ErrCnt and WordCnt.
- One natural sub-module: seq_compare. It registers the Expected value, produces a 1-bit mismatch and the next-expected value, and contains the wrap arithmetic. FSM, counters and snapshot stay in the top.

Test Plan:
- Clean stream: Enable, feed 1..100 contiguous, TARGET_WORDS=100 -> Locked after word 1, ErrCnt=0, ErrFlag=0, WordCnt=100, Done=1 after word 100.
- Gapped stream: 1..50 with DataInValid low on random cycles -> ErrCnt=0, WordCnt=50.
- Dropped word: 1..10, skip 11, then 12..20 -> ErrCnt=1, FirstErrExp=11, FirstErrGot=12, WordCnt=19.
- Corrupt word: 1..5, 0xDEAD, 7..9 -> ErrCnt=2, FirstErrExp=6, FirstErrGot=0xDEAD.
- Wrap: STRICT_START=0, feed 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 -> ErrCnt=0, WordCnt=4.
- Restart/clear:
  - Enable low after 1..10, then high and feed 1..5 -> ErrCnt=0, WordCnt=15.
  - Clear pulse concurrent with a valid word -> all stats 0, state WAIT_FIRST, next word accepted as seed.
  - STRICT_START=1, first word 5 -> ErrCnt=1, FirstErrExp=1, FirstErrGot=5.
